// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser per channel followed by a stability
// counter/FSM that moves the clean level only after STABLE_CYCLES equal samples.
module button_debouncer #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 500000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] button_level,
  output logic [WIDTH-1:0] bounce_active
);

  localparam int               CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] INACTIVE = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    ST_STABLE_0 = 2'd0,
    ST_PEND_1   = 2'd1,
    ST_STABLE_1 = 2'd2,
    ST_PEND_0   = 2'd3
  } state_t;

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_sample;

  // Two-stage synchroniser; reset loads the released pin level
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_sync1 <= INACTIVE;
      r_sync2 <= INACTIVE;
    end else begin
      r_sync1 <= button_raw;
      r_sync2 <= r_sync1;
    end
  end

  // XOR with the released level yields 1 = pressed regardless of polarity
  assign w_sample = r_sync2 ^ INACTIVE;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          r_bounce;

    // Next-state and counter update for one channel
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_STABLE_0: begin
          if (w_sample[g]) begin
            if (SINGLE) begin
              w_state_nxt = ST_STABLE_1;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              w_state_nxt = ST_PEND_1;
              w_cnt_nxt   = CNT_ONE;
            end
          end else begin
            w_cnt_nxt = CNT_ZERO;
          end
        end
        ST_PEND_1: begin
          if (!w_sample[g]) begin
            w_state_nxt = ST_STABLE_0;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_STABLE_1;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_STABLE_1: begin
          if (!w_sample[g]) begin
            if (SINGLE) begin
              w_state_nxt = ST_STABLE_0;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              w_state_nxt = ST_PEND_0;
              w_cnt_nxt   = CNT_ONE;
            end
          end else begin
            w_cnt_nxt = CNT_ZERO;
          end
        end
        ST_PEND_0: begin
          if (w_sample[g]) begin
            w_state_nxt = ST_STABLE_1;
            w_cnt_nxt   = CNT_ZERO;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_STABLE_0;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_STABLE_0;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end

    // State, counter and outputs; outputs decode the next state so they move with it
    always_ff @(posedge clk) begin
      if (sync_reset) begin
        r_state  <= ST_STABLE_0;
        r_cnt    <= CNT_ZERO;
        r_level  <= 1'b0;
        r_bounce <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_level  <= (w_state_nxt == ST_STABLE_1) || (w_state_nxt == ST_PEND_0);
        r_bounce <= (w_state_nxt == ST_PEND_1) || (w_state_nxt == ST_PEND_0);
      end
    end

    assign button_level[g]  = r_level;
    assign bounce_active[g] = r_bounce;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: window-based level model compared every cycle,
// plus directed edge-exact expectations on two parameterisations.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [2:0] raw_a, raw_b;
  logic [2:0] level_a, bounce_a, level_b, bounce_b;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  button_debouncer #(.WIDTH(3), .STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .sync_reset(sync_reset), .button_raw(raw_a),
    .button_level(level_a), .bounce_active(bounce_a));

  button_debouncer #(.WIDTH(3), .STABLE_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .sync_reset(sync_reset), .button_raw(raw_b),
    .button_level(level_b), .bounce_active(bounce_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: s is the raw pin two edges late (polarity removed); level flips once
  // the most recent SC samples all disagree with it.
  logic [2:0]  m_p1[2], m_p2[2], m_level[2], m_bounce[2];
  logic [31:0] m_hist[2][3];
  logic [2:0]  t_inact, t_s, t_raw;
  logic [31:0] t_mask, t_want;
  int          t_sc;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      t_inact = (d == 0) ? 3'b111 : 3'b000;
      t_sc    = (d == 0) ? 4 : 1;
      t_raw   = (d == 0) ? raw_a : raw_b;
      if (sync_reset) begin
        m_p1[d] = t_inact;
        m_p2[d] = t_inact;
        m_level[d] = 3'b000;
        m_bounce[d] = 3'b000;
        for (int c = 0; c < 3; c++) m_hist[d][c] = 32'd0;
      end else begin
        t_s = m_p2[d] ^ t_inact;
        m_p2[d] = m_p1[d];
        m_p1[d] = t_raw;
        t_mask = (32'd1 << t_sc) - 32'd1;
        for (int c = 0; c < 3; c++) begin
          m_hist[d][c] = {m_hist[d][c][30:0], t_s[c]};
          t_want = m_level[d][c] ? 32'd0 : t_mask;
          if ((m_hist[d][c] & t_mask) == t_want) m_level[d][c] = ~m_level[d][c];
          m_bounce[d][c] = (t_s[c] != m_level[d][c]);
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      chk("model_level_a", {29'd0, level_a}, {29'd0, m_level[0]});
      chk("model_bounce_a", {29'd0, bounce_a}, {29'd0, m_bounce[0]});
      chk("model_level_b", {29'd0, level_b}, {29'd0, m_level[1]});
      chk("model_bounce_b", {29'd0, bounce_b}, {29'd0, m_bounce[1]});
    end
  end

  task automatic edge_chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    chk(nm, {29'd0, act}, {29'd0, exp});
  endtask

  int pat[5] = '{0, 1, 0, 0, 1};

  initial begin
    raw_a = 3'b111;
    raw_b = 3'b000;
    sync_reset = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;
    edge_chk("reset_level_a", level_a, 3'b000);
    edge_chk("reset_bounce_a", bounce_a, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk) sync_reset = 1'b0;

    // Idle released buttons
    repeat (20) @(posedge clk); #1;
    edge_chk("idle_level", level_a, 3'b000);
    edge_chk("idle_bounce", bounce_a, 3'b000);

    // Channel 0 press and hold
    @(negedge clk) raw_a = 3'b110;
    @(posedge clk); #1 edge_chk("p0_k_bounce", bounce_a, 3'b000);
    @(posedge clk); #1 edge_chk("p0_k1_bounce", bounce_a, 3'b000);
    @(posedge clk); #1 edge_chk("p0_k2_bounce", bounce_a, 3'b001);
    edge_chk("p0_k2_level", level_a, 3'b000);
    repeat (2) @(posedge clk); #1;
    edge_chk("p0_k4_level", level_a, 3'b000);
    edge_chk("p0_k4_bounce", bounce_a, 3'b001);
    @(posedge clk); #1;
    edge_chk("p0_k5_level", level_a, 3'b001);
    edge_chk("p0_k5_bounce", bounce_a, 3'b000);
    @(negedge clk) raw_a = 3'b111;
    repeat (10) @(posedge clk); #1 edge_chk("p0_release", level_a, 3'b000);

    // Channel 1 bounce then settle pressed
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) raw_a[1] = pat[i][0];
    end
    @(negedge clk) raw_a[1] = 1'b0;
    @(posedge clk);
    repeat (4) @(posedge clk); #1 edge_chk("b1_k4_level", level_a, 3'b000);
    @(posedge clk); #1 edge_chk("b1_k5_level", level_a, 3'b010);
    @(negedge clk) raw_a = 3'b111;
    repeat (10) @(posedge clk);

    // Channels 0 and 2 together, channel 2 released after two samples
    @(negedge clk) raw_a = 3'b010;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) raw_a = 3'b110;
    repeat (3) @(posedge clk); #1 edge_chk("c02_k4_level", level_a, 3'b000);
    @(posedge clk); #1 edge_chk("c02_k5_level", level_a, 3'b001);
    @(negedge clk) raw_a = 3'b111;
    repeat (10) @(posedge clk);

    // Reset while qualifying with cnt=2, button still held
    @(negedge clk) raw_a = 3'b110;
    repeat (4) @(posedge clk);
    @(negedge clk) sync_reset = 1'b1;
    @(posedge clk); #1;
    edge_chk("rst_mid_level", level_a, 3'b000);
    edge_chk("rst_mid_bounce", bounce_a, 3'b000);
    @(negedge clk) sync_reset = 1'b0;
    repeat (3) @(posedge clk); #1 edge_chk("rst_r3_bounce", bounce_a, 3'b001);
    repeat (2) @(posedge clk); #1 edge_chk("rst_r5_level", level_a, 3'b000);
    @(posedge clk); #1 edge_chk("rst_r6_level", level_a, 3'b001);
    @(negedge clk) raw_a = 3'b111;
    repeat (10) @(posedge clk);

    // Active-high, single-sample instance
    @(negedge clk) raw_b = 3'b001;
    @(posedge clk); #1 edge_chk("b_k_level", level_b, 3'b000);
    @(posedge clk); #1 edge_chk("b_k1_level", level_b, 3'b000);
    @(posedge clk); #1 edge_chk("b_k2_level", level_b, 3'b001);
    edge_chk("b_k2_bounce", bounce_b, 3'b000);
    @(negedge clk) raw_b = 3'b000;
    @(posedge clk);
    @(posedge clk); #1 edge_chk("b_m1_level", level_b, 3'b001);
    @(posedge clk); #1 edge_chk("b_m2_level", level_b, 3'b000);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
